// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the CPU load/store unit, the data memory and the IO channels
// of mem_io_bridge. The bridge side uses the slave modport; the environment uses master.
interface mem_io_bridge_if #(
  parameter int N_IO = 4,
  parameter int IO_W = 24
);
  // Handshake: req is sampled only while the bridge is idle (no back-pressure,
  // no queuing); ready pulses high for exactly one cycle when the access completes.
  logic                   req;
  logic                   rd;
  logic                   wr;
  logic [31:0]            addr;
  logic [31:0]            wdata;
  logic [31:0]            rdata;
  logic                   ready;
  logic [31:0]            dmem_addr;
  logic [31:0]            dmem_wdata;
  logic                   dmem_we;
  logic [31:0]            dmem_rdata;
  logic [N_IO-1:0]        io_cs;
  logic                   io_we;
  logic [N_IO*IO_W-1:0]   io_rdata;
  logic [N_IO*IO_W-1:0]   io_wdata;

  modport slave (
    input  req, rd, wr, addr, wdata, dmem_rdata, io_rdata,
    output rdata, ready, dmem_addr, dmem_wdata, dmem_we, io_cs, io_we, io_wdata
  );

  modport master (
    output req, rd, wr, addr, wdata, dmem_rdata, io_rdata,
    input  rdata, ready, dmem_addr, dmem_wdata, dmem_we, io_cs, io_we, io_wdata
  );
endinterface

// File: rtl/mem_io_bridge.sv
// Routes CPU loads/stores either to data memory or to a 1 KiB window of IO channel
// registers. Optional error pulse output is enabled with `define MEMIO_ERR_EN.
module mem_io_bridge #(
  parameter int          N_IO    = 4,
  parameter int          IO_W    = 24,
  parameter logic [31:0] IO_BASE = 32'hFFFFFC00,
  parameter int          IO_WAIT = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  mem_io_bridge_if.slave   bus,
  output logic [1:0]       dbg_state
`ifdef MEMIO_ERR_EN
  ,
  output logic             err
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, MEM = 2'd1, IOW = 2'd2, DONE = 2'd3} state_t;

  localparam int         WAIT_CYC = (IO_WAIT < 1) ? 1 : IO_WAIT;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);
  localparam logic [4:0] N_IO_L   = 5'(N_IO);

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [31:0]           rdata_q, rdata_d;
  logic [N_IO*IO_W-1:0]  io_wdata_q, io_wdata_d;

  logic                  dmem_we_c;
  logic [N_IO-1:0]       io_cs_c;
  logic                  io_we_c;
  logic                  ready_c;
  logic [3:0]            ch;
  logic                  do_read;

  assign ch      = addr_q[5:2];
  // Write wins when both intents are set, so a read only happens with wr clear.
  assign do_read = rd_q & ~wr_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    io_wdata_d = io_wdata_q;
    dmem_we_c  = 1'b0;
    io_cs_c    = '0;
    io_we_c    = 1'b0;
    ready_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          rd_d    = bus.rd;
          wr_d    = bus.wr;
          if (bus.addr[31:10] == IO_BASE[31:10]) begin
            state_d = IOW;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = MEM;
          end
        end
      end
      MEM: begin
        dmem_we_c = wr_q;
        state_d   = DONE;
        if (do_read) rdata_d = bus.dmem_rdata;
      end
      IOW: begin
        io_we_c = wr_q;
        // Channels beyond N_IO never match, so they select nothing and read as zero.
        for (int k = 0; k < N_IO; k++) io_cs_c[k] = (ch == 4'(k));
        if (cnt_q == 4'd0) begin
          state_d = DONE;
          if (do_read) begin
            rdata_d = '0;
            for (int k = 0; k < N_IO; k++)
              if (ch == 4'(k)) rdata_d[IO_W-1:0] = bus.io_rdata[k*IO_W +: IO_W];
          end
          if (wr_q) begin
            for (int k = 0; k < N_IO; k++)
              if (ch == 4'(k)) io_wdata_d[k*IO_W +: IO_W] = wdata_q[IO_W-1:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        ready_c = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      io_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      io_wdata_q <= io_wdata_d;
    end
  end

  assign bus.rdata      = rdata_q;
  assign bus.ready      = ready_c;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.dmem_we    = dmem_we_c;
  assign bus.io_cs      = io_cs_c;
  assign bus.io_we      = io_we_c;
  assign bus.io_wdata   = io_wdata_q;
  assign dbg_state      = state_q;

`ifdef MEMIO_ERR_EN
  logic err_q, err_d;

  // Error cause is decided when the request is accepted and reported with ready.
  always_comb begin
    err_d = err_q;
    if (state_q == IDLE && bus.req)
      err_d = ((bus.addr[31:10] == IO_BASE[31:10]) && ({1'b0, bus.addr[5:2]} >= N_IO_L))
              || (bus.rd && bus.wr);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = ready_c & err_q;
`else
  logic unused_n_io_l;
  assign unused_n_io_l = ^N_IO_L;
`endif

endmodule

// File: tb/tb_mem_io_bridge.sv
// Self-checking bench for mem_io_bridge: directed scenarios plus randomized accesses
// compared against a transaction-level model of memory/IO behaviour.
module tb_mem_io_bridge;

  localparam int          N_IO    = 4;
  localparam int          IO_W    = 24;
  localparam int          IO_WAIT = 2;
  localparam logic [31:0] IO_BASE = 32'hFFFFFC00;
  localparam int          W_CYC   = (IO_WAIT < 1) ? 1 : IO_WAIT;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] dbg_state;
`ifdef MEMIO_ERR_EN
  logic       err;
`endif

  always #5 clock = ~clock;

  mem_io_bridge_if #(.N_IO(N_IO), .IO_W(IO_W)) bus ();

  mem_io_bridge #(.N_IO(N_IO), .IO_W(IO_W), .IO_BASE(IO_BASE), .IO_WAIT(IO_WAIT)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
`ifdef MEMIO_ERR_EN
    ,
    .err       (err)
`endif
  );

  int               n_tests = 0;
  int               n_fail  = 0;
  logic [31:0]      exp_q[$];
  logic [IO_W-1:0]  m_io[N_IO];
  logic [31:0]      m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_rdata = '0;
    for (int k = 0; k < N_IO; k++) m_io[k] = '0;
    exp_q.delete();
  endtask

  task automatic check_io_regs(input string tag);
    for (int k = 0; k < N_IO; k++)
      check_eq(tag, 32'(bus.io_wdata[k*IO_W +: IO_W]), 32'(m_io[k]));
  endtask

  task automatic rand_iod(output logic [N_IO*IO_W-1:0] iod);
    for (int k = 0; k < N_IO; k++) iod[k*IO_W +: IO_W] = IO_W'($urandom);
  endtask

  // One full access: drive req for a cycle, watch the busy cycles, check completion.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] dm,
                         input logic [N_IO*IO_W-1:0] iod, input logic ghost);
    logic            is_io;
    int              ch;
    int              lat;
    int              cyc;
    logic            seen;
    logic [N_IO-1:0] cs_exp;
    logic            err_exp;

    is_io   = (addr[31:10] == IO_BASE[31:10]);
    ch      = int'(addr[5:2]);
    lat     = is_io ? W_CYC + 1 : 2;
    cs_exp  = (is_io && ch < N_IO) ? (N_IO'(1) << ch) : '0;
    err_exp = (is_io && ch >= N_IO) || (rd && wr);

    if (rd && !wr) begin
      if (!is_io)         m_rdata = dm;
      else if (ch < N_IO) m_rdata = 32'(iod[ch*IO_W +: IO_W]);
      else                m_rdata = 32'd0;
    end
    exp_q.push_back(m_rdata);
    if (wr && is_io && ch < N_IO) m_io[ch] = wdata[IO_W-1:0];

    @(negedge clock);
    bus.req = 1'b1; bus.rd = rd; bus.wr = wr; bus.addr = addr; bus.wdata = wdata;
    bus.dmem_rdata = dm; bus.io_rdata = iod;
    @(posedge clock);

    cyc = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      if (bus.ready) begin
        seen = 1'b1;
      end else if (!is_io) begin
        check_eq("mem_we", bus.dmem_we, wr);
        check_eq("mem_cs", 32'(bus.io_cs), 32'd0);
        check_eq("mem_addr", bus.dmem_addr, addr);
        check_eq("mem_wdata", bus.dmem_wdata, wdata);
      end else begin
        check_eq("io_cs", 32'(bus.io_cs), 32'(cs_exp));
        check_eq("io_we", bus.io_we, wr);
        check_eq("io_dmem_we", bus.dmem_we, 1'b0);
      end
      if (cyc == 1) begin
        if (ghost) begin
          bus.req = 1'b1; bus.wr = 1'b1; bus.rd = 1'b0;
          bus.addr = IO_BASE; bus.wdata = $urandom;
        end else begin
          bus.req = 1'b0;
        end
      end else begin
        bus.req = 1'b0;
      end
    end

    check_eq("latency", cyc, lat);
    check_eq("rdata", bus.rdata, exp_q.pop_front());
    check_io_regs("io_wdata");
`ifdef MEMIO_ERR_EN
    check_eq("err", err, err_exp);
`endif
    bus.req = 1'b0;

    @(negedge clock);
    check_eq("ready_once", bus.ready, 1'b0);
    check_eq("idle_cs", 32'(bus.io_cs), 32'd0);
    check_eq("idle_we", {30'd0, bus.dmem_we, bus.io_we}, 32'd0);
`ifdef MEMIO_ERR_EN
    check_eq("err_idle", err, 1'b0);
`endif
  endtask

  task automatic rand_addr(output logic [31:0] addr);
    if ($urandom_range(0, 1) == 1) begin
      addr = {IO_BASE[31:10], 10'($urandom)};
    end else begin
      addr = $urandom;
      while (addr[31:10] == IO_BASE[31:10]) addr = $urandom;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N_IO*IO_W-1:0] iod;
    logic [31:0]          a;
    logic                 saw_ready;

    bus.req = 1'b0; bus.rd = 1'b0; bus.wr = 1'b0; bus.addr = '0; bus.wdata = '0;
    bus.dmem_rdata = '0; bus.io_rdata = '0;
    model_reset();

    repeat (3) @(negedge clock);
    check_eq("rst_rdata", bus.rdata, 32'd0);
    check_eq("rst_daddr", bus.dmem_addr, 32'd0);
    check_eq("rst_dwdata", bus.dmem_wdata, 32'd0);
    check_eq("rst_ctl", {28'd0, bus.ready, bus.dmem_we, bus.io_we, 1'b0}, 32'd0);
    check_eq("rst_cs", 32'(bus.io_cs), 32'd0);
    check_eq("rst_state", dbg_state, 2'd0);
    check_io_regs("rst_io_wdata");
`ifdef MEMIO_ERR_EN
    check_eq("rst_err", err, 1'b0);
`endif
    reset_n = 1'b1;
    @(negedge clock);

    // Memory read with fixed data.
    rand_iod(iod);
    run_txn(1'b1, 1'b0, 32'h40, 32'd0, 32'h12345678, iod, 1'b0);
    check_eq("mem_rd_val", bus.rdata, 32'h12345678);

    // IO write to channel 1.
    rand_iod(iod);
    run_txn(1'b0, 1'b1, 32'hFFFFFC04, 32'hAABBCCDD, $urandom, iod, 1'b0);
    check_eq("io_wr_ch1", 32'(bus.io_wdata[IO_W +: IO_W]), 32'h00BBCCDD);

    // IO read channel 0 with a second req raised during the wait states.
    rand_iod(iod);
    iod[0 +: IO_W] = {IO_W{1'b1}};
    run_txn(1'b1, 1'b0, IO_BASE, 32'd0, $urandom, iod, 1'b1);
    check_eq("io_rd_ch0", bus.rdata, 32'h00FFFFFF);
    check_eq("ghost_state", dbg_state, 2'd0);

    // Out-of-range channel write, then read.
    rand_iod(iod);
    run_txn(1'b0, 1'b1, IO_BASE | 32'h1C, 32'h1, $urandom, iod, 1'b0);
    run_txn(1'b1, 1'b0, IO_BASE | 32'h1C, 32'h0, $urandom, iod, 1'b0);
    check_eq("oor_rd_zero", bus.rdata, 32'd0);

    // Write priority and no-intent accesses on both paths.
    rand_iod(iod);
    run_txn(1'b1, 1'b1, IO_BASE | 32'h8, $urandom, $urandom, iod, 1'b0);
    run_txn(1'b1, 1'b1, 32'h100, $urandom, $urandom, iod, 1'b0);
    run_txn(1'b0, 1'b0, IO_BASE | 32'hC, $urandom, $urandom, iod, 1'b0);
    run_txn(1'b0, 1'b0, 32'h200, $urandom, $urandom, iod, 1'b0);

    // Reset pulse during the wait states of an IO write.
    @(negedge clock);
    bus.req = 1'b1; bus.rd = 1'b0; bus.wr = 1'b1; bus.addr = IO_BASE | 32'h4; bus.wdata = $urandom;
    @(posedge clock);
    @(negedge clock);
    bus.req = 1'b0;
    check_eq("pre_rst_cs", 32'(bus.io_cs), 32'h2);
    #1 reset_n = 1'b0;
    #1 check_eq("rst_abort_state", dbg_state, 2'd0);
    #1 reset_n = 1'b1;
    model_reset();
    saw_ready = 1'b0;
    repeat (6) begin
      @(negedge clock);
      if (bus.ready) saw_ready = 1'b1;
    end
    check_eq("rst_no_ready", saw_ready, 1'b0);
    check_io_regs("rst_abort_io");
    check_eq("rst_abort_rdata", bus.rdata, 32'd0);
    rand_iod(iod);
    run_txn(1'b1, 1'b0, 32'h40, 32'd0, 32'hCAFEF00D, iod, 1'b0);

    // Randomized accesses.
    for (int i = 0; i < 60; i++) begin
      rand_addr(a);
      rand_iod(iod);
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom, $urandom,
              iod, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
